cla_seq_adder: RTL and testbench
================================

Name: cla_seq_adder

Overview:
- Multi-cycle wide adder that time-shares one 4-bit carry-lookahead slice (existing CLA_4) to add WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Provides a start/busy/done handshake and registered result, for use by the ALU-level datapath where area matters more than latency.
- Owns sequencing: operand capture, nibble index counter, carry chaining between slices, result assembly.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (derived localparam, not overridable), number of slice passes.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled on rising clk edge.
- a  input  WIDTH  operand A; captured only when start is accepted.
- b  input  WIDTH  operand B; captured only when start is accepted.
- cin  input  1  carry-in; captured only when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out of MSB nibble.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, index=0, internal carry=0, operand registers=0. Reset mid-RUN aborts; no done pulse.
- States: IDLE, RUN, DONE (encoded in shared package).
- IDLE: start=1 -> capture a, b, cin; index=0; carry=cin; go RUN. start=0 -> stay.
- RUN: busy=1. Each cycle the CLA_4 slice is fed operand nibble [4*index+3:4*index] and carry register. On the edge, the slice sum is written into sum nibble at index, carry register takes slice cout, index increments. On the edge processing index=NIB-1, also register cout and ovf (ovf = slice carry into bit 3 XOR slice cout, derived from the slice's internal carry or a[MSB], b[MSB], sum[MSB]), then go DONE.
- start during RUN is ignored; the captured operands are unaffected by input changes.
- DONE: done=1 for exactly one cycle, busy=0; go IDLE. start=1 in DONE is accepted exactly as in IDLE (back-to-back; go RUN), with no idle bubble.
- Latency: start accepted at edge E0; done high in the cycle following edge E(NIB). For WIDTH=16, done is visible 4 cycles after the accept edge. Throughput: one result per NIB+1 cycles.
- Outputs sum/cout/ovf hold their last values until the next accepted start; they are overwritten nibble-by-nibble during RUN and are valid only when done=1 or afterward in IDLE.
- Index counter width is clog2(NIB), minimum 1; it never wraps within RUN.
- WIDTH=4: RUN lasts one cycle.

Decomposition:
- Shared package cla_seq_pkg: state enum {IDLE, RUN, DONE}, SLICE_W=4 constant.
- One sub-module: the existing CLA_4 (a, b, cin -> sum, cout, P, G), instantiated once; P and G left unused.
- The FSM, counter, and nibble mux/demux stay in cla_seq_adder.

Test Plan (WIDTH=16):
- Reset, then start with a=0x0000, b=0x0000, cin=0 -> done after 4 cycles; sum=0x0000, cout=0, ovf=0; busy high for exactly 4 cycles.
- a=0x0001, b=0x0001, cin=1 -> sum=0x0003, cout=0, ovf=0. Then a=0x0F0F, b=0x00F1, cin=0 -> sum=0x1000 (carry ripples through nibbles 0-2).
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1, ovf=0.
- Start accepted with a=0x1234, b=0x1111; on cycle 2 assert start with a=0xFFFF, b=0xFFFF -> ignored; result sum=0x2345, single done pulse.
- Start held high continuously with a new operand pair given in each DONE cycle -> back-to-back results, done every 5 cycles, no IDLE cycle between.
- Assert rst in cycle 2 of RUN -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse. A subsequent start computes correctly.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared definitions for the nibble-serial CLA adder: sequencer states and slice width.
package cla_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/CLA_4.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs.
module CLA_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       P,
  output logic       G
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
  assign P    = &p;
  assign G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_seq_adder.sv
// Area-lean WIDTH-bit adder: one CLA_4 slice reused per nibble, LSB nibble first,
// with a start/busy/done handshake and registered sum/cout/ovf.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic [NIB-1:0][SLICE_W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic cout_q, cout_d, ovf_q, ovf_d;

  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic sl_co, sl_p_unused, sl_g_unused;
  logic accept;

  assign sl_a = a_q[idx_q];
  assign sl_b = b_q[idx_q];

  CLA_4 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_s),
    .cout (sl_co),
    .P    (sl_p_unused),
    .G    (sl_g_unused)
  );

  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (idx_q == LAST) ? DONE : RUN;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      sum_d[idx_q] = sl_s;
      carry_d      = sl_co;
      if (idx_q == LAST) begin
        cout_d = sl_co;
        // Carry into the MSB recovered as a^b^sum at bit 3 of the top slice.
        ovf_d  = (sl_a[SLICE_W-1] ^ sl_b[SLICE_W-1] ^ sl_s[SLICE_W-1]) ^ sl_co;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized and directed bench for cla_seq_adder (WIDTH=16) against an arithmetic model.
module tb_cla_seq_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum} from plain integer addition.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    ov   = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full};
  endfunction

  // Samples at negedges after the accept edge until done (bounded). Scrambles inputs while running.
  task automatic wait_done(input bit hold, input bit poke, output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (!done) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        if (!hold) start = 1'b0;
        if (poke && cyc == 2) begin
          start = 1'b1;
          a     = '1;
          b     = '1;
          cin   = 1'b1;
        end
      end
    end while (!done && cyc < 20);
  endtask

  task automatic check_result(input string tag, input logic [W+1:0] e, input int cyc, input int bcnt);
    check({tag, "_lat"},  cyc, NIB + 1);
    check({tag, "_busy"}, bcnt, NIB);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_sum"},  {16'd0, sum}, {16'd0, e[W-1:0]});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, e[W]});
    check({tag, "_ovf"},  {31'd0, ovf}, {31'd0, e[W+1]});
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input bit poke, input string tag);
    logic [W+1:0] e;
    int cyc, bcnt;
    e = model(x, y, c);
    @(negedge clk);
    start = 1'b1; a = x; b = y; cin = c;
    wait_done(1'b0, poke, cyc, bcnt);
    check_result(tag, e, cyc, bcnt);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"},  {16'd0, sum}, {16'd0, e[W-1:0]});
  endtask

  logic [W-1:0] pa [4];
  logic [W-1:0] pb [4];
  logic         pc [4];

  initial begin
    int cyc, bcnt;
    bit seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum",  {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf",  {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    do_op(16'h0000, 16'h0000, 1'b0, 1'b0, "zero");
    do_op(16'h0001, 16'h0001, 1'b1, 1'b0, "cin");
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "ripple");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "ovf_pos");
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "all1");
    do_op(16'h1234, 16'h1111, 1'b0, 1'b1, "ignore_start");

    // Start held high: a new operand pair is presented in each DONE cycle.
    for (int k = 0; k < 4; k++) begin
      pa[k] = W'($urandom);
      pb[k] = W'($urandom);
      pc[k] = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b1; a = pa[0]; b = pb[0]; cin = pc[0];
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b1, 1'b0, cyc, bcnt);
      check_result($sformatf("b2b%0d", k), model(pa[k], pb[k], pc[k]), cyc, bcnt);
      if (k < 3) begin
        a = pa[k+1]; b = pb[k+1]; cin = pc[k+1];
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_end_busy", {31'd0, busy}, 32'd0);
    check("b2b_end_done", {31'd0, done}, 32'd0);

    // Leave cout/ovf set so the reset clear is observable, then abort mid-RUN.
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, "neg_ovf");
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum",  {16'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_ovf",  {31'd0, ovf}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_nodone", {31'd0, seen}, 32'd0);
    do_op(16'hABCD, 16'h1357, 1'b1, 1'b0, "after_abort");

    for (int i = 0; i < 25; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, $sformatf("rnd%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
